// File: rtl/lieat_csr_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, op encodings,
// mstatus bit positions and the read-modify-write helper.
package lieat_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  localparam logic [31:0] MISA_VAL = 32'h4000_1104;

  function automatic logic [31:0] csr_modify(input csr_op_e op, input logic [31:0] old_val,
                                             input logic [31:0] wdata);
    logic [31:0] res;
    case (op)
      CSR_OP_RW: res = wdata;
      CSR_OP_RS: res = old_val | wdata;
      CSR_OP_RC: res = old_val & ~wdata;
      default:   res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lieat_csr_counter64.sv
// 64-bit event counter with independently writable halves; a half-write
// replaces that half and suppresses the increment for that cycle.
module lieat_csr_counter64 #(
  parameter int W = 32
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_inc,
  input  logic           i_lo_we,
  input  logic           i_hi_we,
  input  logic [W-1:0]   i_wdata,
  output logic [2*W-1:0] o_cnt
);

  logic [2*W-1:0] r_cnt;

  // Counter state: reset, half-write, or full-width increment with carry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_lo_we) begin
      r_cnt[W-1:0] <= i_wdata;
    end else if (i_hi_we) begin
      r_cnt[2*W-1:W] <= i_wdata;
    end else if (i_inc) begin
      r_cnt <= r_cnt + {{(2*W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/lieat_exu_com_csrfile.sv
// Machine-mode CSR file for the EXU commit stage: CSR RMW instructions,
// trap entry / mret updates, counters, and a bypassed IFU redirect port.
module lieat_exu_com_csrfile
  import lieat_csr_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              HAS_COUNTERS = 1,
  parameter logic [XLEN-1:0] MTVEC_RST    = 32'h0,
  parameter logic [XLEN-1:0] HART_ID      = 32'h0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_csr_ena,
  input  logic [1:0]      i_csr_op,
  input  logic            i_csr_wr_en,
  input  logic [11:0]     i_csr_idx,
  input  logic [XLEN-1:0] i_csr_wdata,
  output logic [XLEN-1:0] o_csr_rdata,
  output logic            o_csr_ilgl,
  input  logic            i_trap_valid,
  input  logic [XLEN-1:0] i_trap_pc,
  input  logic [XLEN-1:0] i_trap_cause,
  input  logic            i_mret_valid,
  input  logic            i_instret_inc,
  input  logic            i_ifu_csr_ren,
  input  logic [11:0]     i_ifu_csr_idx,
  output logic [XLEN-1:0] o_ifu_csr_rdata
);

  localparam logic [XLEN-1:0] LSB1 = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] LSB2 = {{(XLEN-2){1'b0}}, 2'b11};

  logic            r_mie, r_mpie;
  logic [XLEN-1:0] r_mtvec, r_mscratch, r_mepc, r_mcause;
  logic            w_mie_nxt, w_mpie_nxt;
  logic [XLEN-1:0] w_mtvec_nxt, w_mscratch_nxt, w_mepc_nxt, w_mcause_nxt;
  logic [XLEN-1:0] w_mstatus, w_old, w_new;
  logic [2*XLEN-1:0] w_mcycle, w_minstret;
  logic            w_known, w_ro, w_ilgl, w_wr;

  // mstatus view: MPP hardwired to machine mode, only MIE/MPIE stored.
  always_comb begin
    w_mstatus               = '0;
    w_mstatus[12:11]        = 2'b11;
    w_mstatus[MSTATUS_MPIE] = r_mpie;
    w_mstatus[MSTATUS_MIE]  = r_mie;
  end

  // Address decode: old value, known/read-only classification.
  always_comb begin
    w_known = 1'b1;
    w_ro    = 1'b0;
    w_old   = '0;
    case (i_csr_idx)
      CSR_MSTATUS:   w_old = w_mstatus;
      CSR_MISA:      begin w_old = MISA_VAL; w_ro = 1'b1; end
      CSR_MHARTID:   begin w_old = HART_ID;  w_ro = 1'b1; end
      CSR_MTVEC:     w_old = r_mtvec;
      CSR_MSCRATCH:  w_old = r_mscratch;
      CSR_MEPC:      w_old = r_mepc;
      CSR_MCAUSE:    w_old = r_mcause;
      CSR_MCYCLE:    begin w_old = w_mcycle[XLEN-1:0];        w_known = (HAS_COUNTERS != 0); end
      CSR_MCYCLEH:   begin w_old = w_mcycle[2*XLEN-1:XLEN];   w_known = (HAS_COUNTERS != 0); end
      CSR_MINSTRET:  begin w_old = w_minstret[XLEN-1:0];      w_known = (HAS_COUNTERS != 0); end
      CSR_MINSTRETH: begin w_old = w_minstret[2*XLEN-1:XLEN]; w_known = (HAS_COUNTERS != 0); end
      default:       w_known = 1'b0;
    endcase
  end

  assign w_ilgl = i_csr_ena & (~w_known | (w_ro & i_csr_wr_en) | (i_csr_op == 2'b00));
  assign w_wr   = i_csr_ena & i_csr_wr_en & ~w_ilgl;
  assign w_new  = csr_modify(csr_op_e'(i_csr_op), w_old, i_csr_wdata);

  // Next state per field; trap beats mret beats the CSR instruction.
  always_comb begin
    w_mie_nxt      = r_mie;
    w_mpie_nxt     = r_mpie;
    w_mtvec_nxt    = r_mtvec;
    w_mscratch_nxt = r_mscratch;
    w_mepc_nxt     = r_mepc;
    w_mcause_nxt   = r_mcause;
    if (i_trap_valid) begin
      w_mie_nxt  = 1'b0;
      w_mpie_nxt = r_mie;
    end else if (i_mret_valid) begin
      w_mie_nxt  = r_mpie;
      w_mpie_nxt = 1'b1;
    end else if (w_wr && (i_csr_idx == CSR_MSTATUS)) begin
      w_mie_nxt  = w_new[MSTATUS_MIE];
      w_mpie_nxt = w_new[MSTATUS_MPIE];
    end else begin
      w_mie_nxt  = r_mie;
    end
    if (i_trap_valid) begin
      w_mepc_nxt   = i_trap_pc & ~LSB1;
      w_mcause_nxt = i_trap_cause;
    end else if (w_wr && (i_csr_idx == CSR_MEPC)) begin
      w_mepc_nxt = w_new & ~LSB1;
    end else if (w_wr && (i_csr_idx == CSR_MCAUSE)) begin
      w_mcause_nxt = w_new;
    end else begin
      w_mepc_nxt = r_mepc;
    end
    if (w_wr && (i_csr_idx == CSR_MTVEC)) begin
      w_mtvec_nxt = w_new & ~LSB2;
    end else if (w_wr && (i_csr_idx == CSR_MSCRATCH)) begin
      w_mscratch_nxt = w_new;
    end else begin
      w_mtvec_nxt = r_mtvec;
    end
  end

  // Architectural CSR registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mie      <= 1'b0;
      r_mpie     <= 1'b0;
      r_mtvec    <= MTVEC_RST;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
    end else begin
      r_mie      <= w_mie_nxt;
      r_mpie     <= w_mpie_nxt;
      r_mtvec    <= w_mtvec_nxt;
      r_mscratch <= w_mscratch_nxt;
      r_mepc     <= w_mepc_nxt;
      r_mcause   <= w_mcause_nxt;
    end
  end

  generate
    if (HAS_COUNTERS != 0) begin : g_cnt
      lieat_csr_counter64 #(.W(XLEN)) u_mcycle (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (1'b1),
        .i_lo_we (w_wr && (i_csr_idx == CSR_MCYCLE)),
        .i_hi_we (w_wr && (i_csr_idx == CSR_MCYCLEH)),
        .i_wdata (w_new),
        .o_cnt   (w_mcycle)
      );
      lieat_csr_counter64 #(.W(XLEN)) u_minstret (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (i_instret_inc),
        .i_lo_we (w_wr && (i_csr_idx == CSR_MINSTRET)),
        .i_hi_we (w_wr && (i_csr_idx == CSR_MINSTRETH)),
        .i_wdata (w_new),
        .o_cnt   (w_minstret)
      );
    end else begin : g_nocnt
      assign w_mcycle   = '0;
      assign w_minstret = '0;
    end
  endgenerate

  assign o_csr_rdata = (i_csr_ena & ~w_ilgl) ? w_old : '0;
  assign o_csr_ilgl  = w_ilgl;

  // IFU redirect read returns next-state values so same-cycle updates are visible.
  always_comb begin
    o_ifu_csr_rdata = '0;
    if (i_ifu_csr_ren) begin
      case (i_ifu_csr_idx)
        CSR_MTVEC: o_ifu_csr_rdata = w_mtvec_nxt;
        CSR_MEPC:  o_ifu_csr_rdata = w_mepc_nxt;
        default:   o_ifu_csr_rdata = '0;
      endcase
    end else begin
      o_ifu_csr_rdata = '0;
    end
  end

endmodule

// File: tb/tb_lieat_exu_com_csrfile.sv
// Directed bench for the CSR file: expected outputs are queued with each
// stimulus step and compared when the combinational outputs are sampled.
module tb_lieat_exu_com_csrfile;
  import lieat_csr_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_ena, csr_wr_en, trap_valid, mret_valid, instret_inc, ifu_ren;
  logic [1:0]  csr_op;
  logic [11:0] csr_idx, ifu_idx;
  logic [31:0] csr_wdata, trap_pc, trap_cause;
  logic [31:0] csr_rdata, ifu_rdata;
  logic        csr_ilgl;

  typedef struct {
    string       tag;
    bit          chk_rd;
    logic [31:0] rd;
    logic        il;
    logic [31:0] ifu;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  lieat_exu_com_csrfile #(
    .XLEN(32), .HAS_COUNTERS(1), .MTVEC_RST(32'h0000_0200), .HART_ID(32'h0000_0005)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_csr_ena(csr_ena), .i_csr_op(csr_op), .i_csr_wr_en(csr_wr_en),
    .i_csr_idx(csr_idx), .i_csr_wdata(csr_wdata),
    .o_csr_rdata(csr_rdata), .o_csr_ilgl(csr_ilgl),
    .i_trap_valid(trap_valid), .i_trap_pc(trap_pc), .i_trap_cause(trap_cause),
    .i_mret_valid(mret_valid), .i_instret_inc(instret_inc),
    .i_ifu_csr_ren(ifu_ren), .i_ifu_csr_idx(ifu_idx), .o_ifu_csr_rdata(ifu_rdata)
  );

  task automatic idle();
    rst = 1'b0; csr_ena = 1'b0; csr_op = 2'b00; csr_wr_en = 1'b0;
    csr_idx = 12'h000; csr_wdata = 32'h0;
    trap_valid = 1'b0; trap_pc = 32'h0; trap_cause = 32'h0;
    mret_valid = 1'b0; instret_inc = 1'b0; ifu_ren = 1'b0; ifu_idx = 12'h000;
  endtask

  task automatic csr(input logic [1:0] op, input logic wr, input logic [11:0] idx,
                     input logic [31:0] wd);
    csr_ena = 1'b1; csr_op = op; csr_wr_en = wr; csr_idx = idx; csr_wdata = wd;
  endtask

  task automatic rd(input logic [11:0] idx);
    csr(2'b10, 1'b0, idx, 32'h0);
  endtask

  task automatic trap(input logic [31:0] pc, input logic [31:0] cause);
    trap_valid = 1'b1; trap_pc = pc; trap_cause = cause;
  endtask

  task automatic ifu(input logic [11:0] idx);
    ifu_ren = 1'b1; ifu_idx = idx;
  endtask

  task automatic push(input string tag, input bit chk, input logic [31:0] r,
                      input logic il, input logic [31:0] f);
    exp_t e;
    e.tag = tag; e.chk_rd = chk; e.rd = r; e.il = il; e.ifu = f;
    sb.push_back(e);
  endtask

  // Sample at the falling edge, pop the expectation, then advance one cycle.
  task automatic step();
    exp_t e;
    @(negedge clk);
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty: got %0d entries expected >0", sb.size());
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.chk_rd) begin
        checks++;
        assert (csr_rdata === e.rd) else begin
          errors++;
          $error("FAIL %s.rdata: got %h expected %h", e.tag, csr_rdata, e.rd);
        end
      end
      checks++;
      assert (csr_ilgl === e.il) else begin
        errors++;
        $error("FAIL %s.ilgl: got %b expected %b", e.tag, csr_ilgl, e.il);
      end
      checks++;
      assert (ifu_rdata === e.ifu) else begin
        errors++;
        $error("FAIL %s.ifu: got %h expected %h", e.tag, ifu_rdata, e.ifu);
      end
    end
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    idle();
    push("reset", 1'b1, 32'h0, 1'b0, 32'h0); step();
    rd(CSR_MTVEC); ifu(CSR_MTVEC);
    push("rd_mtvec", 1'b1, 32'h0000_0200, 1'b0, 32'h0000_0200); step();
    rd(CSR_MISA);    push("rd_misa", 1'b1, 32'h4000_1104, 1'b0, 32'h0); step();
    rd(CSR_MHARTID); push("rd_hartid", 1'b1, 32'h0000_0005, 1'b0, 32'h0); step();

    csr(2'b01, 1'b1, CSR_MSCRATCH, 32'hA5A5_0000); push("rw_mscratch", 1'b1, 32'h0, 1'b0, 32'h0); step();
    csr(2'b10, 1'b1, CSR_MSCRATCH, 32'h0000_00FF); push("rs_mscratch", 1'b1, 32'hA5A5_0000, 1'b0, 32'h0); step();
    csr(2'b11, 1'b1, CSR_MSCRATCH, 32'h0000_000F); push("rc_mscratch", 1'b1, 32'hA5A5_00FF, 1'b0, 32'h0); step();
    rd(CSR_MSCRATCH); push("rd_mscratch", 1'b1, 32'hA5A5_00F0, 1'b0, 32'h0); step();

    csr(2'b01, 1'b1, CSR_MSTATUS, 32'h0000_0008); push("wr_mstatus", 1'b1, 32'h0000_1800, 1'b0, 32'h0); step();
    rd(CSR_MSTATUS); trap(32'h8000_0103, 32'h0000_000B); ifu(CSR_MEPC);
    push("trap1", 1'b1, 32'h0000_1808, 1'b0, 32'h8000_0102); step();
    rd(CSR_MEPC); ifu(CSR_MEPC); push("rd_mepc", 1'b1, 32'h8000_0102, 1'b0, 32'h8000_0102); step();
    rd(CSR_MCAUSE); push("rd_mcause", 1'b1, 32'h0000_000B, 1'b0, 32'h0); step();
    rd(CSR_MSTATUS); mret_valid = 1'b1; push("mret", 1'b1, 32'h0000_1880, 1'b0, 32'h0); step();
    rd(CSR_MSTATUS); push("post_mret", 1'b1, 32'h0000_1888, 1'b0, 32'h0); step();

    csr(2'b01, 1'b1, CSR_MISA, 32'h0); push("wr_misa", 1'b1, 32'h0, 1'b1, 32'h0); step();
    csr(2'b01, 1'b1, 12'h7C0, 32'h1234); push("wr_unknown", 1'b1, 32'h0, 1'b1, 32'h0); step();
    csr(2'b00, 1'b1, CSR_MSCRATCH, 32'h1); push("op_none", 1'b1, 32'h0, 1'b1, 32'h0); step();
    rd(CSR_MISA); ifu(CSR_MSCRATCH); push("misa_kept", 1'b1, 32'h4000_1104, 1'b0, 32'h0); step();
    rd(CSR_MSCRATCH); push("mscratch_kept", 1'b1, 32'hA5A5_00F0, 1'b0, 32'h0); step();

    csr(2'b01, 1'b1, CSR_MTVEC, 32'h0000_0103); ifu(CSR_MTVEC);
    push("mtvec_bypass", 1'b1, 32'h0000_0200, 1'b0, 32'h0000_0100); step();
    rd(CSR_MTVEC); push("rd_mtvec2", 1'b1, 32'h0000_0100, 1'b0, 32'h0); step();
    csr(2'b01, 1'b1, CSR_MEPC, 32'h0000_1234); trap(32'h0000_4444, 32'h2); ifu(CSR_MEPC);
    push("trap_vs_mepc", 1'b1, 32'h8000_0102, 1'b0, 32'h0000_4444); step();
    rd(CSR_MEPC); push("rd_mepc2", 1'b1, 32'h0000_4444, 1'b0, 32'h0); step();
    csr(2'b01, 1'b1, CSR_MSCRATCH, 32'h0000_0077); trap(32'h0000_0008, 32'h3);
    push("trap_and_mscratch", 1'b1, 32'hA5A5_00F0, 1'b0, 32'h0); step();
    rd(CSR_MSCRATCH); ifu(CSR_MEPC); push("rd_mscratch2", 1'b1, 32'h0000_0077, 1'b0, 32'h0000_0008); step();
    rd(CSR_MCAUSE); push("rd_mcause2", 1'b1, 32'h0000_0003, 1'b0, 32'h0); step();

    csr(2'b01, 1'b1, CSR_MCYCLEH, 32'h0); push("wr_mcycleh", 1'b0, 32'h0, 1'b0, 32'h0); step();
    csr(2'b01, 1'b1, CSR_MCYCLE, 32'hFFFF_FFFF); push("wr_mcycle", 1'b0, 32'h0, 1'b0, 32'h0); step();
    rd(CSR_MCYCLE);  push("mcycle_held", 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0); step();
    rd(CSR_MCYCLEH); push("mcycleh_carry", 1'b1, 32'h0000_0001, 1'b0, 32'h0); step();
    rd(CSR_MCYCLE);  push("mcycle_wrapped", 1'b1, 32'h0000_0001, 1'b0, 32'h0); step();

    csr(2'b01, 1'b1, CSR_MINSTRET, 32'h0000_0010); instret_inc = 1'b1;
    push("wr_minstret", 1'b1, 32'h0, 1'b0, 32'h0); step();
    rd(CSR_MINSTRET); instret_inc = 1'b1; push("minstret_held", 1'b1, 32'h0000_0010, 1'b0, 32'h0); step();
    rd(CSR_MINSTRET);  push("minstret_inc", 1'b1, 32'h0000_0011, 1'b0, 32'h0); step();
    rd(CSR_MINSTRETH); push("minstreth", 1'b1, 32'h0, 1'b0, 32'h0); step();

    rst = 1'b1; csr(2'b01, 1'b1, CSR_MSCRATCH, 32'h0000_0099);
    push("rst_mid", 1'b1, 32'h0000_0077, 1'b0, 32'h0); step();
    rd(CSR_MSCRATCH); ifu(CSR_MTVEC); push("post_rst_mscratch", 1'b1, 32'h0, 1'b0, 32'h0000_0200); step();
    rd(CSR_MSTATUS); push("post_rst_mstatus", 1'b1, 32'h0000_1800, 1'b0, 32'h0); step();
    rd(CSR_MINSTRET); push("post_rst_minstret", 1'b1, 32'h0, 1'b0, 32'h0); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
